// File: rtl/asram_dp_pkg.sv
// Shared types and constants for the dual-port RAM sharing controller.
package asram_dp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int REQ_A  = 0;
    localparam int REQ_B  = 1;
    localparam int RD_LAT = 3;

endpackage

// File: rtl/asram_dp_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: the pointer holder wins a tie, then the
// pointer passes to the other input. A lone eligible input always wins.
module rr_arb2
    import asram_dp_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] elig_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;  // 0 favours requester A

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (&elig_i) begin
                gnt_o[REQ_A] = ~ptr_q;
                gnt_o[REQ_B] = ptr_q;
            end else begin
                gnt_o = elig_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else if (en_i && (&elig_i)) begin
            ptr_q <= ~ptr_q;
        end
    end

endmodule

// File: rtl/asram_dp_ctrl.sv
// Shares one dual-port RAM between requesters A and B; clears the RAM after reset.
// Optional ASRAM_DP_FWD_EN: same-address write/read in one cycle returns the new data.
module asram_dp_ctrl
    import asram_dp_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int address_width = 4,
    parameter int RAM_size      = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     a_req_i,
    input  logic                     a_we_i,
    input  logic [address_width-1:0] a_addr_i,
    input  logic [data_width-1:0]    a_wdata_i,
    output logic                     a_gnt_o,
    output logic                     a_rvalid_o,
    output logic [data_width-1:0]    a_rdata_o,
    input  logic                     b_req_i,
    input  logic                     b_we_i,
    input  logic [address_width-1:0] b_addr_i,
    input  logic [data_width-1:0]    b_wdata_i,
    output logic                     b_gnt_o,
    output logic                     b_rvalid_o,
    output logic [data_width-1:0]    b_rdata_o,
    output logic                     ram_wr_en_o,
    output logic [address_width-1:0] ram_wr_addr_o,
    output logic [data_width-1:0]    ram_data_in_o,
    output logic                     ram_rd_en_o,
    output logic [address_width-1:0] ram_rd_addr_o,
    input  logic [data_width-1:0]    ram_data_out_i,
    output logic                     init_done_o
);

    // Stage 0 of the read pipe is the RAM read strobe itself.
    localparam int PIPE = RD_LAT - 1;
    localparam logic [address_width-1:0] INIT_LAST = address_width'(RAM_size - 1);

    state_t                   state_q;
    logic [address_width-1:0] init_cnt_q;
    logic                     init_done_q;
    logic                     a_gnt_q, b_gnt_q;
    logic                     a_rvalid_q, b_rvalid_q;
    logic [data_width-1:0]    a_rdata_q, b_rdata_q;
    logic                     ram_wr_en_q;
    logic [address_width-1:0] ram_wr_addr_q;
    logic [data_width-1:0]    ram_data_in_q;
    logic [address_width-1:0] ram_rd_addr_q;
    logic [PIPE-1:0]          rd_vld_q;
    logic [PIPE-1:0]          rd_id_q;
    logic [1:0]               wr_elig, rd_elig, wr_gnt, rd_gnt;
    logic                     in_run;
    logic [data_width-1:0]    cap_data;

    assign in_run = (state_q == RUN);

    // A requester granted last cycle sits out one cycle.
    assign wr_elig[REQ_A] = a_req_i &  a_we_i & ~a_gnt_q;
    assign wr_elig[REQ_B] = b_req_i &  b_we_i & ~b_gnt_q;
    assign rd_elig[REQ_A] = a_req_i & ~a_we_i & ~a_gnt_q;
    assign rd_elig[REQ_B] = b_req_i & ~b_we_i & ~b_gnt_q;

    rr_arb2 u_wr_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (in_run),
        .elig_i (wr_elig),
        .gnt_o  (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (in_run),
        .elig_i (rd_elig),
        .gnt_o  (rd_gnt)
    );

`ifdef ASRAM_DP_FWD_EN
    logic                  fwd_hit_q;
    logic [data_width-1:0] fwd_data_q;

    // Compare the issued strobes one cycle after grant, lined up with pipe stage 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= ram_wr_en_q & rd_vld_q[0] & (ram_wr_addr_q == ram_rd_addr_q);
            fwd_data_q <= ram_data_in_q;
        end
    end

    assign cap_data = fwd_hit_q ? fwd_data_q : ram_data_out_i;
`else
    assign cap_data = ram_data_out_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= INIT;
            init_cnt_q    <= '0;
            init_done_q   <= 1'b0;
            a_gnt_q       <= 1'b0;
            b_gnt_q       <= 1'b0;
            a_rvalid_q    <= 1'b0;
            b_rvalid_q    <= 1'b0;
            a_rdata_q     <= '0;
            b_rdata_q     <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_data_in_q <= '0;
            ram_rd_addr_q <= '0;
            rd_vld_q      <= '0;
            rd_id_q       <= '0;
        end else begin
            a_gnt_q    <= wr_gnt[REQ_A] | rd_gnt[REQ_A];
            b_gnt_q    <= wr_gnt[REQ_B] | rd_gnt[REQ_B];
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            rd_vld_q[PIPE-1:1] <= rd_vld_q[PIPE-2:0];
            rd_id_q[PIPE-1:1]  <= rd_id_q[PIPE-2:0];

            if (rd_vld_q[PIPE-1]) begin
                if (rd_id_q[PIPE-1]) begin
                    b_rvalid_q <= 1'b1;
                    b_rdata_q  <= cap_data;
                end else begin
                    a_rvalid_q <= 1'b1;
                    a_rdata_q  <= cap_data;
                end
            end

            case (state_q)
                INIT: begin
                    ram_wr_en_q   <= 1'b1;
                    ram_wr_addr_q <= init_cnt_q;
                    ram_data_in_q <= '0;
                    rd_vld_q[0]   <= 1'b0;
                    init_cnt_q    <= init_cnt_q + address_width'(1);
                    if (init_cnt_q == INIT_LAST) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    ram_wr_en_q <= |wr_gnt;
                    if (wr_gnt[REQ_B]) begin
                        ram_wr_addr_q <= b_addr_i;
                        ram_data_in_q <= b_wdata_i;
                    end else if (wr_gnt[REQ_A]) begin
                        ram_wr_addr_q <= a_addr_i;
                        ram_data_in_q <= a_wdata_i;
                    end
                    rd_vld_q[0] <= |rd_gnt;
                    if (|rd_gnt) begin
                        ram_rd_addr_q <= rd_gnt[REQ_B] ? b_addr_i : a_addr_i;
                        rd_id_q[0]    <= rd_gnt[REQ_B];
                    end
                end
            endcase
        end
    end

    assign a_gnt_o       = a_gnt_q;
    assign b_gnt_o       = b_gnt_q;
    assign a_rvalid_o    = a_rvalid_q;
    assign b_rvalid_o    = b_rvalid_q;
    assign a_rdata_o     = a_rdata_q;
    assign b_rdata_o     = b_rdata_q;
    assign ram_wr_en_o   = ram_wr_en_q;
    assign ram_wr_addr_o = ram_wr_addr_q;
    assign ram_data_in_o = ram_data_in_q;
    assign ram_rd_en_o   = rd_vld_q[0];
    assign ram_rd_addr_o = ram_rd_addr_q;
    assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_asram_dp_ctrl.sv
// Randomized bench for asram_dp_ctrl with a RAM model and a reference scoreboard.
module tb_asram_dp_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int RS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_wr_en, ram_rd_en, init_done;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_data_in, ram_data_out;

    always #5 clk = ~clk;

    asram_dp_ctrl #(.data_width(DW), .address_width(AW), .RAM_size(RS)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_data_in_o(ram_data_in),
        .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr), .ram_data_out_i(ram_data_out),
        .init_done_o(init_done)
    );

    // RAM: synchronous read, read-before-write; poison fills it with junk so clearing is visible.
    logic [DW-1:0] mem [0:RS-1];
    logic          poison;
    always @(posedge clk) begin
        if (poison) begin
            for (int i = 0; i < RS; i++) mem[i] <= DW'($urandom);
        end else begin
            if (ram_rd_en) ram_data_out <= mem[ram_rd_addr];
            if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]    gnt;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic          done;
    } bus_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    bus_t bus_q[$];
    rd_t  rda_q[$];
    rd_t  rdb_q[$];

    int checks = 0;
    int errors = 0;
    logic stop_stim = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic pick(output logic req, output logic we, output logic [AW-1:0] addr,
                        output logic [DW-1:0] wdata);
        req   = ($urandom_range(0, 3) != 0);
        we    = 1'($urandom_range(0, 1));
        addr  = AW'($urandom_range(0, 5));
        wdata = DW'($urandom);
    endtask

    // Requesters: hold an operation until granted, then pick a new one.
    initial begin
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stop_stim) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end else begin
                if (a_gnt || !a_req) pick(a_req, a_we, a_addr, a_wdata);
                if (b_gnt || !b_req) pick(b_req, b_we, b_addr, b_wdata);
            end
        end
    end

    // Reference model: one prediction per upcoming clock edge.
    initial begin : model
        logic [DW-1:0] shadow [0:RS-1];
        int  init_left = RS;
        int  ptr_w = 0, ptr_r = 0;
        logic [1:0] pg = 2'b00;
        forever begin
            bus_t e;
            int   edge_n, wwin, rwin;
            logic [AW-1:0] waddr, raddr;
            logic [DW-1:0] wdata, v;
            bit wa, wb, ra, rb;
            @(negedge clk);
            edge_n = cyc + 1;
            e.gnt = 2'b00; e.wr_en = 1'b0; e.wr_addr = '0; e.wr_data = '0;
            e.rd_en = 1'b0; e.rd_addr = '0; e.done = 1'b0;
            if (rst) begin
                init_left = RS; ptr_w = 0; ptr_r = 0; pg = 2'b00;
                rda_q.delete(); rdb_q.delete();
                for (int i = 0; i < RS; i++) shadow[i] = '0;
            end else if (init_left > 0) begin
                e.wr_en   = 1'b1;
                e.wr_addr = AW'(RS - init_left);
                e.done    = (init_left == 1);
                init_left--;
                pg = 2'b00;
            end else begin
                e.done = 1'b1;
                wa = a_req && a_we && !pg[0];
                wb = b_req && b_we && !pg[1];
                ra = a_req && !a_we && !pg[0];
                rb = b_req && !b_we && !pg[1];
                wwin = -1; rwin = -1;
                if (wa && wb) begin wwin = ptr_w; ptr_w = 1 - ptr_w; end
                else if (wa) wwin = 0;
                else if (wb) wwin = 1;
                if (ra && rb) begin rwin = ptr_r; ptr_r = 1 - ptr_r; end
                else if (ra) rwin = 0;
                else if (rb) rwin = 1;
                waddr = (wwin == 1) ? b_addr : a_addr;
                wdata = (wwin == 1) ? b_wdata : a_wdata;
                raddr = (rwin == 1) ? b_addr : a_addr;
                if (wwin == 0 || rwin == 0) e.gnt[0] = 1'b1;
                if (wwin == 1 || rwin == 1) e.gnt[1] = 1'b1;
                if (rwin >= 0) begin
                    v = shadow[raddr];
`ifdef ASRAM_DP_FWD_EN
                    if (wwin >= 0 && waddr == raddr) v = wdata;
`endif
                    e.rd_en = 1'b1; e.rd_addr = raddr;
                    if (rwin == 0) rda_q.push_back('{data: v, due: edge_n + 2});
                    else           rdb_q.push_back('{data: v, due: edge_n + 2});
                end
                if (wwin >= 0) begin
                    e.wr_en = 1'b1; e.wr_addr = waddr; e.wr_data = wdata;
                    shadow[waddr] = wdata;
                end
                pg = e.gnt;
            end
            bus_q.push_back(e);
        end
    end

    // Monitor: compare what the DUT presents against the scoreboard.
    initial begin
        @(negedge clk);
        forever begin
            bus_t e;
            rd_t  r;
            @(posedge clk);
            #2;
            if (bus_q.size() == 0) begin
                chk("bus_queue_empty", 32'(bus_q.size()), 32'd1);
            end else begin
                e = bus_q.pop_front();
                chk("gnt", 32'({b_gnt, a_gnt}), 32'(e.gnt));
                chk("ram_wr_en", 32'(ram_wr_en), 32'(e.wr_en));
                if (e.wr_en) begin
                    chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e.wr_addr));
                    chk("ram_data_in", 32'(ram_data_in), 32'(e.wr_data));
                end
                chk("ram_rd_en", 32'(ram_rd_en), 32'(e.rd_en));
                if (e.rd_en) chk("ram_rd_addr", 32'(ram_rd_addr), 32'(e.rd_addr));
                chk("init_done", 32'(init_done), 32'(e.done));
            end
            if (a_rvalid) begin
                if (rda_q.size() == 0) chk("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
                else begin
                    r = rda_q.pop_front();
                    chk("a_rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("a_rdata", 32'(a_rdata), 32'(r.data));
                end
            end else if (rda_q.size() != 0 && rda_q[0].due <= cyc) begin
                r = rda_q.pop_front();
                chk("a_rvalid_missing", 32'(a_rvalid), 32'd1);
            end
            if (b_rvalid) begin
                if (rdb_q.size() == 0) chk("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
                else begin
                    r = rdb_q.pop_front();
                    chk("b_rvalid_cycle", 32'(cyc), 32'(r.due));
                    chk("b_rdata", 32'(b_rdata), 32'(r.data));
                end
            end else if (rdb_q.size() != 0 && rdb_q[0].due <= cyc) begin
                r = rdb_q.pop_front();
                chk("b_rvalid_missing", 32'(b_rvalid), 32'd1);
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        poison = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        poison = 1'b0;
        repeat (600) @(posedge clk);

        // Random mid-run resets, including during INIT.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(5, 150)) @(posedge clk);
            #1;
            rst = 1'b1; poison = 1'b1;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            rst = 1'b0; poison = 1'b0;
        end
        repeat (100) @(posedge clk);

        // Reset the cycle after a read grant: that read must never return.
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            do begin
                @(posedge clk);
                #1;
                waited++;
            end while (!ram_rd_en && waited < 300);
            if (!ram_rd_en) chk("rd_grant_timeout", 32'(ram_rd_en), 32'd1);
            rst = 1'b1; poison = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0; poison = 1'b0;
            repeat ($urandom_range(40, 120)) @(posedge clk);
        end

        repeat (400) @(posedge clk);
        #1;
        stop_stim = 1'b1;
        repeat (40) @(posedge clk);
        #3;
        chk("a_reads_outstanding", 32'(rda_q.size()), 32'd0);
        chk("b_reads_outstanding", 32'(rdb_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
